sharp_fb_arbiter: RTL and testbench
===================================

Name: sharp_fb_arbiter

Overview:
- Shares one single-port pixel RAM between two requesters: the 64-colour Sharp memory display driver (read-only, never stalled) and a host pixel writer (valid/ready).
- Manages a double-buffered frame store: the display scans the front bank while the host writes the back bank.
- Bank swaps happen only at a frame boundary, detected on the driver's vsync.
- Sits between the color display driver, the host/SPI pixel-write path and the frame RAM.

Parameters:
- ADDR_W, 16, pixel address width per bank (matches driver addr_o).
- PIX_W, 16, pixel word width (matches driver pixel_data_i).
- FIFO_DEPTH, 4, write FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- disp_vsync_i  in  1  frame-start strobe from the display driver
- disp_addr_i  in  ADDR_W  display read address
- disp_read_valid_i  in  1  display read request this cycle
- disp_pixel_data_o  out  PIX_W  read data, valid the cycle after disp_read_valid_i
- wr_valid_i  in  1  host write request
- wr_ready_o  out  1  host write accepted when valid&ready
- wr_addr_i  in  ADDR_W  host pixel address (back bank)
- wr_data_i  in  PIX_W  host pixel data
- swap_req_i  in  1  single-cycle pulse: request front/back swap
- swap_pending_o  out  1  swap requested, not yet done
- swap_done_o  out  1  one-cycle pulse when swap takes effect
- front_bank_o  out  1  bank currently scanned by display
- mem_en_o  out  1  RAM enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W+1  {bank, addr}
- mem_wdata_o  out  PIX_W  RAM write data
- mem_rdata_i  in  PIX_W  RAM read data, 1-cycle latency

Behaviour:
- Reset values: wr_ready_o=0 during reset, swap_pending_o=0, swap_done_o=0, front_bank_o=0, disp_pixel_data_o=0, mem_en_o=0, mem_we_o=0. FIFO is flushed. All requests are ignored while reset_i=1.
- RAM port priority, per cycle:
  - If disp_read_valid_i=1: mem_en_o=1, mem_we_o=0, mem_addr_o={front_bank_o, disp_addr_i}. Display is never stalled.
  - Else if FIFO is non-empty: pop the head and issue the write. mem_en_o=1, mem_we_o=1, mem_addr_o={~front_bank_o, entry.addr}, mem_wdata_o=entry.data.
  - Else: mem_en_o=0.
- RAM port outputs are combinational from the current inputs and FIFO head.
- Read return:
  - rd_q registers disp_read_valid_i.
  - disp_pixel_data_o = rd_q ? mem_rdata_i : hold_q.
  - hold_q captures mem_rdata_i when rd_q=1.
  - Latency is exactly 1 cycle, back-to-back reads every cycle.
- Write FIFO:
  - wr_ready_o = !full && !swap_pending_o.
  - Push on wr_valid_i && wr_ready_o.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - There is no full-bypass: when full, ready is 0 even if a pop happens that cycle.
- Swap state machine:
  - IDLE: swap_req_i goes to PENDING (swap_pending_o=1).
  - PENDING: new writes are blocked and the FIFO drains. On a vsync rising edge (disp_vsync_i=1 && vsync_q=0) with the FIFO empty: toggle front_bank_o, pulse swap_done_o, go to IDLE.
  - If the FIFO is non-empty at the edge, stay PENDING and wait for the next vsync edge.
  - swap_req_i while PENDING is ignored (no double toggle).
  - swap_req_i coincident with a vsync edge in IDLE only enters PENDING; the swap waits for the next edge.
- Bank flip timing: front_bank_o changes on the clock after the edge cycle. A display read in the edge cycle itself uses the old bank. A FIFO write popped in the edge cycle is impossible, because the FIFO is empty.
- vsync_q resets to 0. A vsync high at reset release is seen as an edge only if the IDLE/PENDING rules permit.

Decomposition:
- Package sharp_fb_pkg:
  - Constants SHARP_FB_ADDR_W=16, SHARP_FB_PIX_W=16.
  - Typedef wr_entry_t struct {addr, data}.
  - Enum swap_state_e {SWAP_IDLE, SWAP_PENDING}.
- One sub-module: sharp_fb_wr_fifo. Synchronous FIFO of wr_entry_t with push/pop/full/empty, same clk_i/reset_i.

Test Plan:
- Reset then idle: front_bank_o=0, wr_ready_o=1 after reset, mem_en_o=0, disp_pixel_data_o=0.
- Host writes 3 words (addr 0x0010..0x0012, data 0xA5A0..0xA5A2) with no display traffic: mem_we_o pulses with mem_addr_o=0x1_0010..0x1_0012 in order, one cycle each.
- Display reads every cycle for 10 cycles while host pushes 6 writes:
  - Writes stall; wr_ready_o drops after 4 accepted.
  - All 6 writes complete in order once reads stop.
  - Read data returns exactly 1 cycle after each read.
- swap_req_i with 2 queued writes and a display-read burst covering the first vsync edge:
  - Reads hold off the drain, so FIFO is non-empty at the first edge; no swap.
  - Writes drain after the burst.
  - Swap occurs on the second vsync edge: swap_done_o pulses once, front_bank_o=1, and subsequent reads use mem_addr_o[16]=1.
- swap_req_i twice before a vsync edge with FIFO empty: exactly one toggle.
- Reset asserted mid-PENDING with FIFO holding 3 entries: after reset, FIFO empty, front_bank_o=0, no writes are issued.

Source files
------------

// File: rtl/sharp_fb_pkg.sv
// Shared types and constants for the Sharp display frame-buffer arbiter.
package sharp_fb_pkg;

  localparam int SHARP_FB_ADDR_W = 16;
  localparam int SHARP_FB_PIX_W  = 16;

  typedef struct packed {
    logic [SHARP_FB_ADDR_W-1:0] addr;
    logic [SHARP_FB_PIX_W-1:0]  data;
  } wr_entry_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/sharp_fb_wr_fifo.sv
// Small synchronous FIFO of host pixel writes waiting for a free RAM cycle.
module sharp_fb_wr_fifo
  import sharp_fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      push_i,
  input  wr_entry_t push_entry_i,
  input  logic      pop_i,
  output wr_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push_s, do_pop_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o    = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_i;
    end
  end

endmodule

// File: rtl/sharp_fb_arbiter.sv
// Single-port frame RAM arbiter: display reads always win, host writes queue
// into the back bank, and bank swaps happen only on a vsync rising edge.
module sharp_fb_arbiter
  import sharp_fb_pkg::*;
#(
  parameter int ADDR_W     = SHARP_FB_ADDR_W,
  parameter int PIX_W      = SHARP_FB_PIX_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              disp_vsync_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  input  logic              disp_read_valid_i,
  output logic [PIX_W-1:0]  disp_pixel_data_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic              swap_req_i,
  output logic              swap_pending_o,
  output logic              swap_done_o,
  output logic              front_bank_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W:0]   mem_addr_o,
  output logic [PIX_W-1:0]  mem_wdata_o,
  input  logic [PIX_W-1:0]  mem_rdata_i
);

  swap_state_e      swap_state_q, swap_state_d;
  logic             front_bank_q, front_bank_d;
  logic             swap_done_q, swap_done_d;
  logic             vsync_q, rd_q;
  logic [PIX_W-1:0] hold_q, hold_d;

  wr_entry_t        push_entry_s, head_s;
  logic             full_s, empty_s, push_s, pop_s, vsync_edge_s;

  assign swap_pending_o    = (swap_state_q == SWAP_PENDING);
  assign swap_done_o       = swap_done_q;
  assign front_bank_o      = front_bank_q;
  assign wr_ready_o        = !reset_i && !full_s && !swap_pending_o;
  assign push_s            = wr_valid_i && wr_ready_o;
  assign push_entry_s      = '{addr: wr_addr_i, data: wr_data_i};
  assign vsync_edge_s      = disp_vsync_i && !vsync_q;
  assign disp_pixel_data_o = rd_q ? mem_rdata_i : hold_q;

  sharp_fb_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push_s),
    .push_entry_i(push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  // Display read owns the port; queued writes only fill idle cycles.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {front_bank_q, disp_addr_i};
    mem_wdata_o = head_s.data;
    pop_s       = 1'b0;
    if (reset_i) begin
      mem_en_o = 1'b0;
    end else if (disp_read_valid_i) begin
      mem_en_o = 1'b1;
    end else if (!empty_s) begin
      mem_en_o   = 1'b1;
      mem_we_o   = 1'b1;
      mem_addr_o = {~front_bank_q, head_s.addr};
      pop_s      = 1'b1;
    end else begin
      mem_en_o = 1'b0;
    end
  end

  always_comb begin
    swap_state_d = swap_state_q;
    front_bank_d = front_bank_q;
    swap_done_d  = 1'b0;
    hold_d       = rd_q ? mem_rdata_i : hold_q;
    case (swap_state_q)
      SWAP_IDLE: begin
        if (swap_req_i) begin
          swap_state_d = SWAP_PENDING;
        end else begin
          swap_state_d = SWAP_IDLE;
        end
      end
      SWAP_PENDING: begin
        // Writes are blocked here, so an empty FIFO means the back bank is final.
        if (vsync_edge_s && empty_s) begin
          swap_state_d = SWAP_IDLE;
          front_bank_d = ~front_bank_q;
          swap_done_d  = 1'b1;
        end else begin
          swap_state_d = SWAP_PENDING;
        end
      end
      default: begin
        swap_state_d = SWAP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      swap_state_q <= SWAP_IDLE;
      front_bank_q <= 1'b0;
      swap_done_q  <= 1'b0;
      vsync_q      <= 1'b0;
      rd_q         <= 1'b0;
      hold_q       <= '0;
    end else begin
      swap_state_q <= swap_state_d;
      front_bank_q <= front_bank_d;
      swap_done_q  <= swap_done_d;
      vsync_q      <= disp_vsync_i;
      rd_q         <= disp_read_valid_i;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_sharp_fb_arbiter.sv
// Directed bench for sharp_fb_arbiter with a queue-based behavioural model
// checked every cycle, plus literal expectations on key scenarios.
module tb_sharp_fb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        disp_vsync_i = 1'b0;
  logic [15:0] disp_addr_i = 16'h0000;
  logic        disp_read_valid_i = 1'b0;
  logic [15:0] disp_pixel_data_o;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [15:0] wr_addr_i = 16'h0000;
  logic [15:0] wr_data_i = 16'h0000;
  logic        swap_req_i = 1'b0;
  logic        swap_pending_o, swap_done_o, front_bank_o;
  logic        mem_en_o, mem_we_o;
  logic [16:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i = 16'h0000;

  int checks = 0;
  int errors = 0;
  int accepted_total = 0;
  int done_cnt = 0;

  sharp_fb_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i), .disp_vsync_i(disp_vsync_i),
    .disp_addr_i(disp_addr_i), .disp_read_valid_i(disp_read_valid_i),
    .disp_pixel_data_o(disp_pixel_data_o), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .swap_req_i(swap_req_i), .swap_pending_o(swap_pending_o),
    .swap_done_o(swap_done_o), .front_bank_o(front_bank_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Environment RAM (1-cycle read latency) and a log of every write issued.
  logic [15:0] ram  [131072];
  logic [15:0] mram [131072];
  logic [32:0] wlog [$];

  initial begin
    for (int i = 0; i < 131072; i++) begin
      ram[i]  = 16'(i) ^ 16'h5A5A;
      mram[i] = 16'(i) ^ 16'h5A5A;
    end
  end

  always @(posedge clk_i) begin
    if (mem_en_o === 1'b1) begin
      if (mem_we_o) begin
        ram[mem_addr_o] <= mem_wdata_o;
        wlog.push_back({mem_addr_o, mem_wdata_o});
      end else begin
        mem_rdata_i <= ram[mem_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of pending writes, current bank, pending flag.
  logic [31:0] mq [$];
  logic        m_bank = 1'b0, m_pend = 1'b0, m_done = 1'b0, m_vprev = 1'b0, m_rd = 1'b0;
  logic [16:0] m_rd_addr = 17'h0;
  logic [15:0] m_hold = 16'h0;

  always @(negedge clk_i) begin
    logic        exp_ready, was_empty, edge_s;
    logic [15:0] rdata;
    logic [31:0] e;
    if (reset_i) begin
      chk("rst_wr_ready", 32'(wr_ready_o), 32'h0);
      chk("rst_mem_en", 32'(mem_en_o), 32'h0);
      mq.delete();
      m_bank = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_vprev = 1'b0;
      m_rd = 1'b0; m_hold = 16'h0;
    end else begin
      exp_ready = (mq.size() < 4) && !m_pend;
      rdata = m_rd ? mram[m_rd_addr] : m_hold;
      if (swap_done_o === 1'b1) done_cnt++;
      chk("wr_ready", 32'(wr_ready_o), 32'(exp_ready));
      chk("front_bank", 32'(front_bank_o), 32'(m_bank));
      chk("swap_pending", 32'(swap_pending_o), 32'(m_pend));
      chk("swap_done", 32'(swap_done_o), 32'(m_done));
      chk("disp_data", 32'(disp_pixel_data_o), 32'(rdata));
      was_empty = (mq.size() == 0);
      if (disp_read_valid_i) begin
        chk("mem_en_rd", 32'(mem_en_o), 32'h1);
        chk("mem_we_rd", 32'(mem_we_o), 32'h0);
        chk("mem_addr_rd", 32'(mem_addr_o), 32'({m_bank, disp_addr_i}));
      end else if (!was_empty) begin
        e = mq.pop_front();
        chk("mem_en_wr", 32'(mem_en_o), 32'h1);
        chk("mem_we_wr", 32'(mem_we_o), 32'h1);
        chk("mem_addr_wr", 32'(mem_addr_o), 32'({~m_bank, e[31:16]}));
        chk("mem_wdata", 32'(mem_wdata_o), 32'(e[15:0]));
        mram[{~m_bank, e[31:16]}] = e[15:0];
      end else begin
        chk("mem_en_idle", 32'(mem_en_o), 32'h0);
      end
      if (wr_valid_i && exp_ready) mq.push_back({wr_addr_i, wr_data_i});
      edge_s = disp_vsync_i && !m_vprev;
      m_rd_addr = {m_bank, disp_addr_i};
      m_hold = rdata;
      m_rd = disp_read_valid_i;
      m_vprev = disp_vsync_i;
      m_done = 1'b0;
      if (m_pend) begin
        if (edge_s && was_empty) begin
          m_bank = ~m_bank; m_pend = 1'b0; m_done = 1'b1;
        end
      end else if (swap_req_i) begin
        m_pend = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_words(input int n, input logic [15:0] a0, input logic [15:0] d0);
    int k = 0;
    int budget = 0;
    while (k < n && budget < 200) begin
      wr_valid_i = 1'b1;
      wr_addr_i  = a0 + 16'(k);
      wr_data_i  = d0 + 16'(k);
      @(negedge clk_i);
      if (wr_ready_o === 1'b1) begin
        k++;
        accepted_total++;
      end
      step(1);
      budget++;
    end
    wr_valid_i = 1'b0;
    if (k < n) begin
      checks++; errors++;
      $display("FAIL push_timeout got %0d want %0d", k, n);
    end
  endtask

  task automatic reads(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      disp_read_valid_i = 1'b1;
      disp_addr_i = base + 16'(i);
      step(1);
    end
    disp_read_valid_i = 1'b0;
  endtask

  task automatic vsync_pulse();
    disp_vsync_i = 1'b1;
    step(2);
    disp_vsync_i = 1'b0;
    step(1);
  endtask

  task automatic swap_pulse();
    swap_req_i = 1'b1;
    step(1);
    swap_req_i = 1'b0;
  endtask

  initial begin
    int snap, d0;
    reset_i = 1'b1;
    step(3);
    reset_i = 1'b0;
    step(1);
    @(negedge clk_i);
    chk("idle_front_bank", 32'(front_bank_o), 32'h0);
    chk("idle_wr_ready", 32'(wr_ready_o), 32'h1);
    chk("idle_mem_en", 32'(mem_en_o), 32'h0);
    chk("idle_disp_data", 32'(disp_pixel_data_o), 32'h0);
    step(1);

    // Three host writes with no display traffic.
    wlog.delete();
    push_words(3, 16'h0010, 16'hA5A0);
    step(3);
    chk("w3_count", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      chk("w3_addr", 32'(wlog[i][32:16]), 32'h10010 + 32'(i));
      chk("w3_data", 32'(wlog[i][15:0]), 32'hA5A0 + 32'(i));
    end

    // Read burst starves the writer; four accepted before ready drops.
    wlog.delete();
    snap = accepted_total;
    fork
      begin reads(10, 16'h0100); d0 = accepted_total - snap; end
      push_words(6, 16'h0020, 16'hB000);
    join
    chk("burst_accepted", 32'(d0), 32'd4);
    step(6);
    chk("burst_wcount", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      chk("burst_addr", 32'(wlog[i][32:16]), 32'h10020 + 32'(i));
    end

    // Swap deferred past an edge where the FIFO still holds writes.
    snap = done_cnt;
    fork
      reads(12, 16'h0200);
      begin
        push_words(2, 16'h0030, 16'hC000);
        swap_pulse();
        step(1);
        vsync_pulse();
      end
    join
    chk("swap_not_yet", 32'(done_cnt - snap), 32'd0);
    step(4);
    vsync_pulse();
    step(2);
    chk("swap_once", 32'(done_cnt - snap), 32'd1);
    chk("swap_bank1", 32'(front_bank_o), 32'h1);
    disp_read_valid_i = 1'b1;
    disp_addr_i = 16'h0005;
    @(negedge clk_i);
    chk("read_bank1", 32'(mem_addr_o[16]), 32'h1);
    step(1);
    disp_read_valid_i = 1'b0;
    step(1);

    // Double request before the edge toggles only once.
    snap = done_cnt;
    swap_pulse();
    step(2);
    swap_pulse();
    step(2);
    vsync_pulse();
    step(3);
    chk("dbl_once", 32'(done_cnt - snap), 32'd1);
    chk("dbl_bank0", 32'(front_bank_o), 32'h0);

    // Reset while pending with three queued writes.
    fork
      reads(6, 16'h0300);
      begin push_words(3, 16'h0040, 16'hD000); swap_pulse(); end
    join
    wlog.delete();
    reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
    step(6);
    chk("rst_no_writes", 32'(wlog.size()), 32'd0);
    chk("rst_front_bank", 32'(front_bank_o), 32'h0);
    chk("rst_pending", 32'(swap_pending_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
